// File: rtl/fusion_fetch_pkg.sv
// Shared constants and state encoding for the Fusion-Core fetch unit.
package fusion_fetch_pkg;
    localparam int INSN_W = 32;
    localparam logic [INSN_W-1:0] FUSION_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKID = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC holding register used while decode is stalled.
module fetch_skid_buf
    import fusion_fetch_pkg::*;
(
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              load_in,
    input  logic              unload_in,
    input  logic              clear_in,
    input  logic [INSN_W-1:0] data_in,
    input  logic [31:0]       pc_in,
    output logic              full_out,
    output logic [INSN_W-1:0] data_out,
    output logic [31:0]       pc_out
);
    logic              full_d, full_q;
    logic [INSN_W-1:0] data_d, data_q;
    logic [31:0]       pc_d, pc_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        pc_d   = pc_q;
        if (clear_in || unload_in) begin
            full_d = 1'b0;
        end else if (load_in) begin
            full_d = 1'b1;
            data_d = data_in;
            pc_d   = pc_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            full_q <= 1'b0;
            data_q <= FUSION_NOP;
            pc_q   <= 32'h0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            pc_q   <= pc_d;
        end
    end

    assign full_out = full_q;
    assign data_out = data_q;
    assign pc_out   = pc_q;
endmodule

// File: rtl/fetch_32.sv
// Instruction fetch: one outstanding imem read, one skid word, PC redirects
// from branch resolution that may orphan an in-flight read (DROP state).
module fetch_32
    import fusion_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              stall_in,
    input  logic              pc_change_rel_in,
    input  logic              pc_change_abs_in,
    input  logic [31:0]       branch_pc_in,
    input  logic [20:0]       offset_in,
    input  logic [31:0]       target_in,
    output logic              imem_req_out,
    output logic [31:0]       imem_addr_out,
    input  logic              imem_ack_in,
    input  logic [INSN_W-1:0] imem_data_in,
    output logic [INSN_W-1:0] insn_out,
    output logic [31:0]       insn_pc_out,
    output logic              insn_valid_out
);
    fetch_state_e      state_d, state_q;
    logic [31:0]       pc_d, pc_q;
    logic [31:0]       drop_addr_d, drop_addr_q;
    logic [INSN_W-1:0] insn_d, insn_q;
    logic [31:0]       insn_pc_d, insn_pc_q;
    logic              valid_d, valid_q;

    logic              redirect, outstanding, ack_ok;
    logic [31:0]       rel_target, target;
    logic              skid_load, skid_unload, skid_clear, skid_full;
    logic [INSN_W-1:0] skid_data;
    logic [31:0]       skid_pc;

    assign redirect   = pc_change_rel_in | pc_change_abs_in;
    assign rel_target = branch_pc_in + {{11{offset_in[20]}}, offset_in};
    assign target     = word_align(pc_change_abs_in ? target_in : rel_target);

    // Skid is only ever full in SKID, so RUN always requests.
    always_comb begin
        imem_req_out  = reset_in && (state_q == ST_RUN || state_q == ST_DROP);
        imem_addr_out = (state_q == ST_DROP) ? drop_addr_q : pc_q;
    end

    assign ack_ok      = imem_req_out && imem_ack_in;
    assign outstanding = imem_req_out && !imem_ack_in;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (ack_ok && stall_in) state_d = ST_SKID;
            ST_SKID: if (!stall_in) state_d = ST_RUN;
            ST_DROP: if (imem_ack_in) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        if (redirect) state_d = outstanding ? ST_DROP : ST_RUN;
    end

    always_comb begin
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        insn_d      = insn_q;
        insn_pc_d   = insn_pc_q;
        valid_d     = valid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        if (redirect) begin
            // Any ack in this cycle is dropped; a still-pending one is orphaned.
            pc_d       = target;
            insn_d     = FUSION_NOP;
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            if (outstanding) drop_addr_d = imem_addr_out;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ack_ok) begin
                        pc_d = pc_q + 32'd4;
                        if (stall_in) begin
                            skid_load = 1'b1;
                        end else begin
                            insn_d    = imem_data_in;
                            insn_pc_d = pc_q;
                            valid_d   = 1'b1;
                        end
                    end else if (!stall_in) begin
                        insn_d  = FUSION_NOP;
                        valid_d = 1'b0;
                    end
                end
                ST_SKID: begin
                    if (!stall_in) begin
                        insn_d      = skid_data;
                        insn_pc_d   = skid_pc;
                        valid_d     = 1'b1;
                        skid_unload = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            insn_q      <= FUSION_NOP;
            insn_pc_q   <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            insn_q      <= insn_d;
            insn_pc_q   <= insn_pc_d;
            valid_q     <= valid_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .load_in   (skid_load),
        .unload_in (skid_unload),
        .clear_in  (skid_clear),
        .data_in   (imem_data_in),
        .pc_in     (pc_q),
        .full_out  (skid_full),
        .data_out  (skid_data),
        .pc_out    (skid_pc)
    );

    assign insn_out       = insn_q;
    assign insn_pc_out    = insn_pc_q;
    assign insn_valid_out = valid_q;

    // Skid occupancy and SKID state must always agree.
    wire unused_ok = skid_full;
endmodule

// File: tb/tb_fetch_32.sv
// Directed bench for fetch_32: imem model with programmable ack latency,
// scoreboard of expected (pc, insn) pairs popped as decode receives them.
module tb_fetch_32;
    logic        clk = 1'b0;
    logic        reset_in, stall_in, pc_change_rel_in, pc_change_abs_in;
    logic [31:0] branch_pc_in, target_in;
    logic [20:0] offset_in;
    logic        imem_req_out, imem_ack_in;
    logic [31:0] imem_addr_out, imem_data_in;
    logic [31:0] insn_out, insn_pc_out;
    logic        insn_valid_out;

    int n_cmp = 0;
    int n_err = 0;
    int mem_lat = 0;
    int cnt = 0;
    logic stall_prev = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_32 dut (
        .clk_in           (clk),
        .reset_in         (reset_in),
        .stall_in         (stall_in),
        .pc_change_rel_in (pc_change_rel_in),
        .pc_change_abs_in (pc_change_abs_in),
        .branch_pc_in     (branch_pc_in),
        .offset_in        (offset_in),
        .target_in        (target_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_ack_in      (imem_ack_in),
        .imem_data_in     (imem_data_in),
        .insn_out         (insn_out),
        .insn_pc_out      (insn_pc_out),
        .insn_valid_out   (insn_valid_out)
    );

    // Memory model: word at address A holds A/4; ack after mem_lat wait cycles.
    always_comb begin
        imem_ack_in  = imem_req_out && (cnt == mem_lat);
        imem_data_in = imem_addr_out >> 2;
    end

    always @(posedge clk) begin
        if (!reset_in || !imem_req_out || imem_ack_in) cnt <= 0;
        else cnt <= cnt + 1;
        stall_prev <= stall_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.insn = pc >> 2;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int lat);
        reset_in = 1'b0;
        stall_in = 1'b0;
        pc_change_rel_in = 1'b0;
        pc_change_abs_in = 1'b0;
        mem_lat = lat;
        repeat (2) tick();
    endtask

    // A new instruction reaches decode only if the previous edge was not stalled.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_in && insn_valid_out && !stall_prev && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_pc", insn_pc_out, e.pc);
            chk("sb_insn", insn_out, e.insn);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        branch_pc_in = 32'h0;
        offset_in    = 21'h0;
        target_in    = 32'h0;
        do_reset(0);
        chk("rst_req", {31'h0, imem_req_out}, 32'h0);
        chk("rst_addr", imem_addr_out, 32'h0);
        chk("rst_insn", insn_out, 32'h0);
        chk("rst_insn_pc", insn_pc_out, 32'h0);
        chk("rst_valid", {31'h0, insn_valid_out}, 32'h0);

        // zero-wait streaming
        push(32'h0); push(32'h4); push(32'h8);
        reset_in = 1'b1;
        #1;
        chk("t1_req", {31'h0, imem_req_out}, 32'h1);
        chk("t1_addr0", imem_addr_out, 32'h0);
        tick();
        chk("t1_valid", {31'h0, insn_valid_out}, 32'h1);
        chk("t1_addr1", imem_addr_out, 32'h4);
        tick();
        chk("t1_addr2", imem_addr_out, 32'h8);
        tick();
        chk("t1_addr3", imem_addr_out, 32'hC);
        #1 chk("t1_drain", sb.size(), 32'h0);

        // 3-cycle ack latency
        do_reset(2);
        push(32'h0); push(32'h4);
        reset_in = 1'b1;
        tick();
        chk("t2_valid1", {31'h0, insn_valid_out}, 32'h0);
        chk("t2_addr1", imem_addr_out, 32'h0);
        tick();
        chk("t2_addr2", imem_addr_out, 32'h0);
        tick();
        chk("t2_valid3", {31'h0, insn_valid_out}, 32'h1);
        chk("t2_addr3", imem_addr_out, 32'h4);
        tick();
        chk("t2_valid4", {31'h0, insn_valid_out}, 32'h0);
        tick();
        tick();
        chk("t2_valid6", {31'h0, insn_valid_out}, 32'h1);
        #1 chk("t2_drain", sb.size(), 32'h0);

        // stall with an ack landing in the skid
        do_reset(0);
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        reset_in = 1'b1;
        tick();
        tick();
        chk("t3_addr", imem_addr_out, 32'h8);
        stall_in = 1'b1;
        tick();
        chk("t3_noreq", {31'h0, imem_req_out}, 32'h0);
        tick();
        chk("t3_hold_insn", insn_out, 32'h1);
        tick();
        chk("t3_hold_pc", insn_pc_out, 32'h4);
        chk("t3_hold_valid", {31'h0, insn_valid_out}, 32'h1);
        tick();
        chk("t3_noreq2", {31'h0, imem_req_out}, 32'h0);
        stall_in = 1'b0;
        tick();
        chk("t3_req", {31'h0, imem_req_out}, 32'h1);
        chk("t3_addr_c", imem_addr_out, 32'hC);
        tick();
        #1 chk("t3_drain", sb.size(), 32'h0);

        // absolute redirect, nothing outstanding
        do_reset(0);
        push(32'h0); push(32'h100);
        reset_in = 1'b1;
        tick();
        pc_change_abs_in = 1'b1;
        target_in = 32'h0000_0102;
        tick();
        chk("t4_addr", imem_addr_out, 32'h100);
        chk("t4_valid", {31'h0, insn_valid_out}, 32'h0);
        pc_change_abs_in = 1'b0;
        tick();
        #1 chk("t4_drain", sb.size(), 32'h0);

        // abs+rel together, then a wrapping relative target
        do_reset(0);
        push(32'h200); push(32'h4);
        pc_change_abs_in = 1'b1;
        target_in = 32'h200;
        pc_change_rel_in = 1'b1;
        branch_pc_in = 32'h40;
        offset_in = 21'h8;
        reset_in = 1'b1;
        tick();
        chk("t6_abs_wins", imem_addr_out, 32'h200);
        chk("t6_valid", {31'h0, insn_valid_out}, 32'h0);
        pc_change_abs_in = 1'b0;
        pc_change_rel_in = 1'b0;
        tick();
        pc_change_rel_in = 1'b1;
        branch_pc_in = 32'hFFFF_FFF0;
        offset_in = 21'h17;
        tick();
        chk("t6_wrap", imem_addr_out, 32'h4);
        chk("t6_valid2", {31'h0, insn_valid_out}, 32'h0);
        pc_change_rel_in = 1'b0;
        tick();
        #1 chk("t6_drain", sb.size(), 32'h0);

        // relative redirect over an unacked request
        do_reset(2);
        push(32'h38);
        pc_change_rel_in = 1'b1;
        branch_pc_in = 32'h40;
        offset_in = 21'h1F_FFF8;
        reset_in = 1'b1;
        tick();
        pc_change_rel_in = 1'b0;
        chk("t5_stale_req", {31'h0, imem_req_out}, 32'h1);
        chk("t5_stale_addr1", imem_addr_out, 32'h0);
        chk("t5_valid1", {31'h0, insn_valid_out}, 32'h0);
        tick();
        chk("t5_stale_addr2", imem_addr_out, 32'h0);
        tick();
        chk("t5_target", imem_addr_out, 32'h38);
        chk("t5_valid3", {31'h0, insn_valid_out}, 32'h0);
        tick();
        chk("t5_valid4", {31'h0, insn_valid_out}, 32'h0);
        tick();
        tick();
        #1 chk("t5_drain", sb.size(), 32'h0);

        // reset mid-request
        reset_in = 1'b0;
        #1 chk("t7_req_low", {31'h0, imem_req_out}, 32'h0);
        tick();
        chk("t7_addr", imem_addr_out, 32'h0);
        chk("t7_insn", insn_out, 32'h0);
        chk("t7_insn_pc", insn_pc_out, 32'h0);
        chk("t7_valid", {31'h0, insn_valid_out}, 32'h0);
        reset_in = 1'b1;
        #1;
        chk("t7_req", {31'h0, imem_req_out}, 32'h1);
        chk("t7_addr0", imem_addr_out, 32'h0);
        tick();
        chk("t7_no_ghost", {31'h0, insn_valid_out}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_32.md
# fetch_32

Instruction fetch unit for the Fusion-Core base pipeline. Drives the decode stage's `insn_in`/`insn_pc_in` and the matching fetch-side handshake. Issues word reads to instruction memory over a req/ack interface, tracks the PC, honours decode stall, and applies relative or absolute PC redirects from branch resolution. Holds at most one outstanding memory request plus one skid word.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk_in`  in  1: clock, all state on rising edge.
- `reset_in`  in  1: reset, synchronous, active-low.
- `stall_in`  in  1: decode cannot accept a new instruction; hold outputs.
- `pc_change_rel_in`  in  1: redirect, target = `branch_pc_in` + sext(`offset_in`).
- `pc_change_abs_in`  in  1: redirect, target = `target_in`; wins over relative.
- `branch_pc_in`  in  32: PC of the redirecting instruction.
- `offset_in`  in  21: signed byte offset, sign-extended to 32.
- `target_in`  in  32: absolute target.
- `imem_req_out`  out  1: read request; held with address stable until ack.
- `imem_addr_out`  out  32: word-aligned read address.
- `imem_ack_in`  in  1: read complete; `imem_data_in` valid this cycle.
- `imem_data_in`  in  32: instruction word.
- `insn_out`  out  32: instruction to decode.
- `insn_pc_out`  out  32: address of `insn_out`.
- `insn_valid_out`  out  1: `insn_out` is a real fetched instruction.

## Operation
- Redirect targets: bits [1:0] forced to 0; sums wrap modulo 2^32.
- States: RUN (request may be issued), SKID (one word buffered, stall active), DROP (stale request outstanding, its ack discarded).
- RUN: `imem_req_out`=1 with `imem_addr_out`=pc unless stalled with the skid full. On ack with no stall: `insn_out`<=data, `insn_pc_out`<=addr, valid<=1, pc<=pc+4. On ack with `stall_in`: word goes to skid, pc+=4, go to SKID. No ack and no stall: valid<=0, `insn_out`<=NOP.
- SKID: no new request; outputs held. When `stall_in` drops: skid word goes to outputs, skid empties, return to RUN.
- Stall with no ack and no skid: outputs held, the current request stays asserted.
- Redirect (either change input, any state): pc<=target, skid cleared, `insn_out`<=NOP, valid<=0; overrides stall. If a request is outstanding and unacked in that cycle, go to DROP, else RUN. An ack arriving in the redirect cycle is discarded.
- DROP: keep req/addr of the stale fetch until ack, discard the data, then RUN issuing target. A second redirect in DROP updates pc only.
- Exactly-one-in-flight rule: `imem_addr_out` never changes while req=1 and ack=0.

## Timing
- Reset values: `imem_req_out`=0, `imem_addr_out`=RESET_PC, `insn_out`=NOP (32'h0000_0000), `insn_pc_out`=0, `insn_valid_out`=0, state RUN, skid empty, pc=RESET_PC.
- First cycle after `reset_in` returns high: req=1, addr=RESET_PC.
- Latency: ack in cycle N yields `insn_out` valid in cycle N+1.
- Zero-wait memory (ack in the same cycle as req) gives 1 insn/cycle.
- Redirect sampled in cycle N: `imem_addr_out`=target in N+1 when nothing is outstanding.
- Reset mid-request: all state is cleared and any later ack is ignored until a new req is issued. The memory side must also be reset.

## Structure
- Package `fusion_fetch_pkg`: `FUSION_NOP` (32'h0000_0000), `INSN_W`=32, state encoding (RUN/SKID/DROP).
- Sub-module `fetch_skid_buf`: 1-entry data+PC register with load/unload/clear.
- Target adder and priority mux live inline in `fetch_32`.

## Test plan
- Reset release, zero-wait memory returning addr/4: addrs 0,4,8,12 consecutive. `insn_out` = 0,1,2 one cycle later. valid=1 from the 2nd cycle.
- 3-cycle ack latency: addr held stable for 3 cycles. One valid insn per 3 cycles, NOP/invalid otherwise.
- `stall_in` for 4 cycles with an ack during the stall: outputs frozen, no new req. Skid word (pc 0x8) appears the cycle stall drops, then pc 0xC is fetched.
- Absolute redirect to 0x0000_0102 with nothing outstanding: next addr 0x100, valid=0 for one cycle.
- Relative redirect (`branch_pc_in`=0x40, offset=-8) while an unacked request is out: stale ack is dropped, then addr 0x38 is issued. Simultaneous abs+rel: abs target is used.
- `reset_in` low mid-request with a pending ack: all outputs return to reset values and `imem_req_out`=0 during reset.
